// File: rtl/kaydedici_yazma_hakemi.sv
// kaydedici_yazma_hakemi
//   Shares the single register-file write port between the ALU writeback path (alu_*) and the
//   load writeback path (bel_*). It uses round-robin arbitration with one grant per cycle. It
//   also keeps a per-register busy scoreboard and stalls decode on RAW/WAW hazards.
//
// Parameters
//   VERI_GENISLIK      write data width
//   ADRES_GENISLIK     register address width (2**ADRES_GENISLIK registers)
//   BASLANGIC_ONCELIK  requester favoured first after reset: 0 = ALU, 1 = load
//
// Ports
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   alu_gecerli_i/hedef_i/sonuc_i    ALU writeback request (valid, rd, data)
//   alu_hazir_o                      ALU request accepted this cycle (comb)
//   bel_gecerli_i/hedef_i/sonuc_i    load writeback request (valid, rd, data)
//   bel_hazir_o                      load request accepted this cycle (comb)
//   rezerv_i, rezerv_hedef_i         decode issues a buyruk writing rezerv_hedef_i
//   kaynak_a_i, kaynak_b_i           rs1 / rs2 of the buyruk in decode
//   durdur_o                         decode stall (comb)
//   regfile_wen_o                    register-file write enable (registered)
//   hedef_adres_o, sonuc_o           register-file rd / write data (registered)
//   mesgul_o                         scoreboard busy bits, bit 0 always 0
//
// Optional feature: macro YAZMA_ILETIM_EN adds the forwarding outputs ilet_a_o/ilet_b_o and
// ilet_a_gecerli_o/ilet_b_gecerli_o. It also masks the busy bit that is being cleared out of
// durdur_o, so decode can issue in the writeback cycle.

module kaydedici_yazma_hakemi #(
    parameter int unsigned VERI_GENISLIK     = 32,
    parameter int unsigned ADRES_GENISLIK    = 5,
    parameter bit          BASLANGIC_ONCELIK = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,

    input  logic                            alu_gecerli_i,
    output logic                            alu_hazir_o,
    input  logic [ADRES_GENISLIK-1:0]       alu_hedef_i,
    input  logic [VERI_GENISLIK-1:0]        alu_sonuc_i,

    input  logic                            bel_gecerli_i,
    output logic                            bel_hazir_o,
    input  logic [ADRES_GENISLIK-1:0]       bel_hedef_i,
    input  logic [VERI_GENISLIK-1:0]        bel_sonuc_i,

    input  logic                            rezerv_i,
    input  logic [ADRES_GENISLIK-1:0]       rezerv_hedef_i,
    input  logic [ADRES_GENISLIK-1:0]       kaynak_a_i,
    input  logic [ADRES_GENISLIK-1:0]       kaynak_b_i,
    output logic                            durdur_o,

    output logic                            regfile_wen_o,
    output logic [ADRES_GENISLIK-1:0]       hedef_adres_o,
    output logic [VERI_GENISLIK-1:0]        sonuc_o,
    output logic [(2**ADRES_GENISLIK)-1:0]  mesgul_o
`ifdef YAZMA_ILETIM_EN
    ,
    output logic [VERI_GENISLIK-1:0]        ilet_a_o,
    output logic [VERI_GENISLIK-1:0]        ilet_b_o,
    output logic                            ilet_a_gecerli_o,
    output logic                            ilet_b_gecerli_o
`endif
);

    localparam int unsigned KAYIT_SAYISI = 2 ** ADRES_GENISLIK;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                       oncelik_q, oncelik_d;   // 1: load favoured on a tie
    logic                       yaz_q, yaz_d;
    logic [ADRES_GENISLIK-1:0]  hedef_q, hedef_d;
    logic [VERI_GENISLIK-1:0]   sonuc_q, sonuc_d;
    logic [KAYIT_SAYISI-1:0]    mesgul_q, mesgul_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                       alu_izin, bel_izin, izin_var;
    logic [ADRES_GENISLIK-1:0]  secili_hedef;
    logic [VERI_GENISLIK-1:0]   secili_sonuc;

    always_comb begin
        alu_izin = 1'b0;
        bel_izin = 1'b0;
        // No grants while reset is asserted, so a pending request cannot slip through.
        if (rst_ni) begin
            if (alu_gecerli_i && bel_gecerli_i) begin
                if (oncelik_q) begin
                    bel_izin = 1'b1;
                end else begin
                    alu_izin = 1'b1;
                end
            end else if (alu_gecerli_i) begin
                alu_izin = 1'b1;
            end else if (bel_gecerli_i) begin
                bel_izin = 1'b1;
            end
        end

        // The pointer moves only on a grant and then favours the other requester.
        oncelik_d = oncelik_q;
        if (alu_izin) begin
            oncelik_d = 1'b1;
        end else if (bel_izin) begin
            oncelik_d = 1'b0;
        end
    end

    assign izin_var     = alu_izin | bel_izin;
    assign secili_hedef = bel_izin ? bel_hedef_i : alu_hedef_i;
    assign secili_sonuc = bel_izin ? bel_sonuc_i : alu_sonuc_i;

    // ------------------------------------------------------------------
    // Write stage
    // ------------------------------------------------------------------
    always_comb begin
        // A grant to rd 0 is accepted and its payload is captured, but no write is issued.
        yaz_d   = izin_var && (secili_hedef != '0);
        hedef_d = hedef_q;
        sonuc_d = sonuc_q;
        if (izin_var) begin
            hedef_d = secili_hedef;
            sonuc_d = secili_sonuc;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [KAYIT_SAYISI-1:0] temizle;       // bit being cleared by this cycle's write
    logic [KAYIT_SAYISI-1:0] etkin_mesgul;  // busy bits seen by the hazard check
    logic [KAYIT_SAYISI-1:0] ayir;          // bit being reserved this cycle

    always_comb begin
        temizle = '0;
        for (int unsigned i = 1; i < KAYIT_SAYISI; i++) begin
            temizle[i] = yaz_q && (hedef_q == ADRES_GENISLIK'(i));
        end
    end

    always_comb begin
`ifdef YAZMA_ILETIM_EN
        // The writer forwards its data this cycle, so the clearing bit no longer blocks decode.
        etkin_mesgul = mesgul_q & ~temizle;
`else
        etkin_mesgul = mesgul_q;
`endif
        etkin_mesgul[0] = 1'b0;
    end

    assign durdur_o = rezerv_i & (etkin_mesgul[kaynak_a_i] |
                                  etkin_mesgul[kaynak_b_i] |
                                  etkin_mesgul[rezerv_hedef_i]);

    always_comb begin
        ayir = '0;
        for (int unsigned i = 1; i < KAYIT_SAYISI; i++) begin
            ayir[i] = rezerv_i && !durdur_o && (rezerv_hedef_i == ADRES_GENISLIK'(i));
        end
        // OR-ing the set after the clear lets a new owner win over a retiring write.
        mesgul_d = (mesgul_q & ~temizle) | ayir;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            oncelik_q <= BASLANGIC_ONCELIK;
            yaz_q     <= 1'b0;
            hedef_q   <= '0;
            sonuc_q   <= '0;
            mesgul_q  <= '0;
        end else begin
            oncelik_q <= oncelik_d;
            yaz_q     <= yaz_d;
            hedef_q   <= hedef_d;
            sonuc_q   <= sonuc_d;
            mesgul_q  <= mesgul_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_hazir_o   = alu_izin;
    assign bel_hazir_o   = bel_izin;
    assign regfile_wen_o = yaz_q;
    assign hedef_adres_o = hedef_q;
    assign sonuc_o       = sonuc_q;
    assign mesgul_o      = mesgul_q;

`ifdef YAZMA_ILETIM_EN
    assign ilet_a_gecerli_o = yaz_q && (hedef_q == kaynak_a_i) && (kaynak_a_i != '0);
    assign ilet_b_gecerli_o = yaz_q && (hedef_q == kaynak_b_i) && (kaynak_b_i != '0);
    assign ilet_a_o         = sonuc_q;
    assign ilet_b_o         = sonuc_q;
`endif

endmodule

// File: tb/tb_kaydedici_yazma_hakemi.sv
// Directed bench for kaydedici_yazma_hakemi: reset, single grant, round-robin, RAW stall and
// release, rd 0, same-cycle set/clear, and reset with pending requests.
module tb_kaydedici_yazma_hakemi;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alu_gecerli_i, bel_gecerli_i;
    logic        alu_hazir_o, bel_hazir_o;
    logic [4:0]  alu_hedef_i, bel_hedef_i;
    logic [31:0] alu_sonuc_i, bel_sonuc_i;
    logic        rezerv_i;
    logic [4:0]  rezerv_hedef_i, kaynak_a_i, kaynak_b_i;
    logic        durdur_o;
    logic        regfile_wen_o;
    logic [4:0]  hedef_adres_o;
    logic [31:0] sonuc_o;
    logic [31:0] mesgul_o;
`ifdef YAZMA_ILETIM_EN
    logic [31:0] ilet_a_o, ilet_b_o;
    logic        ilet_a_gecerli_o, ilet_b_gecerli_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    kaydedici_yazma_hakemi #(
        .VERI_GENISLIK     (32),
        .ADRES_GENISLIK    (5),
        .BASLANGIC_ONCELIK (1'b1)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .alu_gecerli_i    (alu_gecerli_i),
        .alu_hazir_o      (alu_hazir_o),
        .alu_hedef_i      (alu_hedef_i),
        .alu_sonuc_i      (alu_sonuc_i),
        .bel_gecerli_i    (bel_gecerli_i),
        .bel_hazir_o      (bel_hazir_o),
        .bel_hedef_i      (bel_hedef_i),
        .bel_sonuc_i      (bel_sonuc_i),
        .rezerv_i         (rezerv_i),
        .rezerv_hedef_i   (rezerv_hedef_i),
        .kaynak_a_i       (kaynak_a_i),
        .kaynak_b_i       (kaynak_b_i),
        .durdur_o         (durdur_o),
        .regfile_wen_o    (regfile_wen_o),
        .hedef_adres_o    (hedef_adres_o),
        .sonuc_o          (sonuc_o),
        .mesgul_o         (mesgul_o)
`ifdef YAZMA_ILETIM_EN
        ,
        .ilet_a_o         (ilet_a_o),
        .ilet_b_o         (ilet_b_o),
        .ilet_a_gecerli_o (ilet_a_gecerli_o),
        .ilet_b_gecerli_o (ilet_b_gecerli_o)
`endif
    );

    // Advance one clock; inputs are driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        alu_gecerli_i = 1'b1;
        bel_gecerli_i = 1'b1;
        alu_hedef_i   = 5'd1;
        bel_hedef_i   = 5'd2;
        tick();
        tick();
        #1;
        checks++; if (alu_hazir_o !== 1'b0) begin failures++;
            $display("FAIL reset_alu_hazir got=%b exp=0", alu_hazir_o); end
        checks++; if (bel_hazir_o !== 1'b0) begin failures++;
            $display("FAIL reset_bel_hazir got=%b exp=0", bel_hazir_o); end
        checks++; if (regfile_wen_o !== 1'b0) begin failures++;
            $display("FAIL reset_wen got=%b exp=0", regfile_wen_o); end
        checks++; if (hedef_adres_o !== 5'd0 || sonuc_o !== 32'd0) begin failures++;
            $display("FAIL reset_payload got=%0d/%h exp=0/0", hedef_adres_o, sonuc_o); end
        checks++; if (mesgul_o !== 32'd0) begin failures++;
            $display("FAIL reset_mesgul got=%h exp=0", mesgul_o); end
        alu_gecerli_i = 1'b0;
        bel_gecerli_i = 1'b0;
        rst_ni        = 1'b1;
        tick();
    endtask

    task automatic test_tek_alu();
        alu_gecerli_i = 1'b1;
        alu_hedef_i   = 5'd5;
        alu_sonuc_i   = 32'h0000_0012;
        #1;
        checks++; if (alu_hazir_o !== 1'b1 || bel_hazir_o !== 1'b0) begin failures++;
            $display("FAIL tek_alu_hazir got=%b%b exp=10", alu_hazir_o, bel_hazir_o); end
        tick();
        alu_gecerli_i = 1'b0;
        #1;
        checks++; if (regfile_wen_o !== 1'b1 || hedef_adres_o !== 5'd5 ||
                      sonuc_o !== 32'h12) begin failures++;
            $display("FAIL tek_alu_yaz got=%b/%0d/%h exp=1/5/12",
                     regfile_wen_o, hedef_adres_o, sonuc_o); end
        tick();
        #1;
        checks++; if (regfile_wen_o !== 1'b0 || hedef_adres_o !== 5'd5 ||
                      mesgul_o !== 32'd0) begin failures++;
            $display("FAIL tek_alu_bos got=%b/%0d/%h exp=0/5/0",
                     regfile_wen_o, hedef_adres_o, mesgul_o); end
    endtask

    // Pointer favours the load path here: bel, alu, bel.
    task automatic test_back_to_back();
        logic       exp_bel [3];
        logic [4:0] exp_hedef [3];
        exp_bel   = '{1'b1, 1'b0, 1'b1};
        exp_hedef = '{5'd4, 5'd3, 5'd4};
        alu_gecerli_i = 1'b1; alu_hedef_i = 5'd3; alu_sonuc_i = 32'hAAAA_0003;
        bel_gecerli_i = 1'b1; bel_hedef_i = 5'd4; bel_sonuc_i = 32'hBBBB_0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bel_hazir_o !== exp_bel[i] || alu_hazir_o !== !exp_bel[i]) begin
                failures++;
                $display("FAIL rr_grant%0d got=alu%b bel%b exp bel=%b",
                         i, alu_hazir_o, bel_hazir_o, exp_bel[i]); end
            tick();
            if (i == 2) begin
                alu_gecerli_i = 1'b0;
                bel_gecerli_i = 1'b0;
            end
            #1;
            checks++; if (regfile_wen_o !== 1'b1 || hedef_adres_o !== exp_hedef[i] ||
                          sonuc_o !== (exp_bel[i] ? 32'hBBBB_0004 : 32'hAAAA_0003)) begin
                failures++;
                $display("FAIL rr_yaz%0d got=%b/%0d/%h exp hedef=%0d",
                         i, regfile_wen_o, hedef_adres_o, sonuc_o, exp_hedef[i]); end
        end
        tick();
        #1;
        checks++; if (regfile_wen_o !== 1'b0) begin failures++;
            $display("FAIL rr_bitis got=%b exp=0", regfile_wen_o); end
    endtask

    task automatic test_raw_durdur();
        rezerv_i = 1'b1; rezerv_hedef_i = 5'd7; kaynak_a_i = 5'd0; kaynak_b_i = 5'd0;
        #1;
        checks++; if (durdur_o !== 1'b0) begin failures++;
            $display("FAIL raw_ilk_durdur got=%b exp=0", durdur_o); end
        tick();
        rezerv_hedef_i = 5'd8; kaynak_a_i = 5'd7;
        #1;
        checks++; if (mesgul_o !== 32'h80 || durdur_o !== 1'b1) begin failures++;
            $display("FAIL raw_durdur got=%h/%b exp=80/1", mesgul_o, durdur_o); end
        bel_gecerli_i = 1'b1; bel_hedef_i = 5'd7; bel_sonuc_i = 32'h0000_0077;
        #1;
        checks++; if (bel_hazir_o !== 1'b1 || durdur_o !== 1'b1) begin failures++;
            $display("FAIL raw_bel_hazir got=%b/%b exp=1/1", bel_hazir_o, durdur_o); end
        tick();
        bel_gecerli_i = 1'b0;
        #1;
`ifdef YAZMA_ILETIM_EN
        checks++; if (regfile_wen_o !== 1'b1 || durdur_o !== 1'b0) begin failures++;
            $display("FAIL raw_wen_dongu got=%b/%b exp=1/0", regfile_wen_o, durdur_o); end
        checks++; if (ilet_a_gecerli_o !== 1'b1 || ilet_a_o !== 32'h77 ||
                      ilet_b_gecerli_o !== 1'b0) begin failures++;
            $display("FAIL raw_ilet got=%b/%h/%b exp=1/77/0",
                     ilet_a_gecerli_o, ilet_a_o, ilet_b_gecerli_o); end
        tick();
        rezerv_i = 1'b0;
        #1;
`else
        checks++; if (regfile_wen_o !== 1'b1 || durdur_o !== 1'b1) begin failures++;
            $display("FAIL raw_wen_dongu got=%b/%b exp=1/1", regfile_wen_o, durdur_o); end
        tick();
        #1;
        checks++; if (mesgul_o !== 32'h0 || durdur_o !== 1'b0) begin failures++;
            $display("FAIL raw_sonra got=%h/%b exp=0/0", mesgul_o, durdur_o); end
        tick();
        rezerv_i = 1'b0;
        #1;
`endif
        checks++; if (mesgul_o !== 32'h100) begin failures++;
            $display("FAIL raw_mesgul got=%h exp=100", mesgul_o); end
        kaynak_a_i = 5'd0;
    endtask

    task automatic test_rd_sifir();
        alu_gecerli_i = 1'b1; alu_hedef_i = 5'd0; alu_sonuc_i = 32'hFFFF_FFFF;
        #1;
        checks++; if (alu_hazir_o !== 1'b1) begin failures++;
            $display("FAIL rd0_hazir got=%b exp=1", alu_hazir_o); end
        tick();
        alu_gecerli_i = 1'b0;
        #1;
        checks++; if (regfile_wen_o !== 1'b0 || mesgul_o !== 32'h100) begin failures++;
            $display("FAIL rd0_yaz got=%b/%h exp=0/100", regfile_wen_o, mesgul_o); end
    endtask

    task automatic test_ayni_dongu();
        rezerv_i = 1'b1; rezerv_hedef_i = 5'd9;
        tick();
        rezerv_i = 1'b0;
        #1;
        checks++; if (mesgul_o !== 32'h300) begin failures++;
            $display("FAIL ayni_ayir got=%h exp=300", mesgul_o); end
        alu_gecerli_i = 1'b1; alu_hedef_i = 5'd9; alu_sonuc_i = 32'h99;
        tick();
        alu_gecerli_i = 1'b0;
        rezerv_i = 1'b1; rezerv_hedef_i = 5'd9;
        #1;
`ifdef YAZMA_ILETIM_EN
        checks++; if (regfile_wen_o !== 1'b1 || durdur_o !== 1'b0) begin failures++;
            $display("FAIL ayni_wen got=%b/%b exp=1/0", regfile_wen_o, durdur_o); end
`else
        checks++; if (regfile_wen_o !== 1'b1 || durdur_o !== 1'b1) begin failures++;
            $display("FAIL ayni_wen got=%b/%b exp=1/1", regfile_wen_o, durdur_o); end
        tick();
        #1;
        checks++; if (mesgul_o !== 32'h100 || durdur_o !== 1'b0) begin failures++;
            $display("FAIL ayni_sonra got=%h/%b exp=100/0", mesgul_o, durdur_o); end
`endif
        tick();
        rezerv_i = 1'b0;
        #1;
        checks++; if (mesgul_o !== 32'h300) begin failures++;
            $display("FAIL ayni_kazanan got=%h exp=300", mesgul_o); end
    endtask

    task automatic test_reset_bekleyen();
        // Reserve 7 while the load path retires 8, leaving 0x280.
        rezerv_i = 1'b1; rezerv_hedef_i = 5'd7;
        bel_gecerli_i = 1'b1; bel_hedef_i = 5'd8; bel_sonuc_i = 32'h88;
        tick();
        rezerv_i = 1'b0; bel_gecerli_i = 1'b0;
        tick();
        #1;
        checks++; if (mesgul_o !== 32'h280) begin failures++;
            $display("FAIL rst_on_mesgul got=%h exp=280", mesgul_o); end
        alu_gecerli_i = 1'b1; alu_hedef_i = 5'd3; alu_sonuc_i = 32'h33;
        bel_gecerli_i = 1'b1; bel_hedef_i = 5'd4; bel_sonuc_i = 32'h44;
        rst_ni = 1'b0;
        #1;
        checks++; if (alu_hazir_o !== 1'b0 || bel_hazir_o !== 1'b0) begin failures++;
            $display("FAIL rst_hazir got=%b%b exp=00", alu_hazir_o, bel_hazir_o); end
        tick();
        #1;
        checks++; if (regfile_wen_o !== 1'b0 || mesgul_o !== 32'h0 ||
                      hedef_adres_o !== 5'd0 || sonuc_o !== 32'h0) begin failures++;
            $display("FAIL rst_sonra got=%b/%h/%0d/%h exp=0/0/0/0",
                     regfile_wen_o, mesgul_o, hedef_adres_o, sonuc_o); end
        rst_ni = 1'b1;
        #1;
        checks++; if (bel_hazir_o !== 1'b1 || alu_hazir_o !== 1'b0) begin failures++;
            $display("FAIL rst_oncelik got=alu%b bel%b exp bel", alu_hazir_o, bel_hazir_o); end
        tick();
        alu_gecerli_i = 1'b0; bel_gecerli_i = 1'b0;
        #1;
        checks++; if (regfile_wen_o !== 1'b1 || hedef_adres_o !== 5'd4) begin failures++;
            $display("FAIL rst_ilk_yaz got=%b/%0d exp=1/4", regfile_wen_o, hedef_adres_o); end
    endtask

    initial begin
        rst_ni = 1'b0;
        alu_gecerli_i = 1'b0; alu_hedef_i = '0; alu_sonuc_i = '0;
        bel_gecerli_i = 1'b0; bel_hedef_i = '0; bel_sonuc_i = '0;
        rezerv_i = 1'b0; rezerv_hedef_i = '0; kaynak_a_i = '0; kaynak_b_i = '0;
        test_reset();
        test_tek_alu();
        test_back_to_back();
        test_raw_durdur();
        test_rd_sifir();
        test_ayni_dongu();
        test_reset_bekleyen();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
